simon_sequencer: RTL and testbench
==================================

Name: simon_sequencer

Overview:
- Game controller that sequences the Simon Says display grid: generates the colour pattern, plays it back, checks player presses, and advances the level.
- Drives the grid renderer's color[3:0], level[2:0] and state[1:0] inputs directly.
- Sits between the debounced push-button front end and the grid renderer, in the single pixel-clock domain.

Parameters:
- T_ON, 25000000: cycles a colour is lit during playback and during player echo.
- T_OFF, 12500000: cycles of dark gap between playback colours and before each new round.
- MAX_LEVEL, 5: final level, range 1..7; completing it wins.
- TIMEOUT, 150000000: player idle limit in cycles; used only with SIMON_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new game
- btn  in  4  debounced one-cycle press pulses; bit2 red, bit1 yellow, bit0 green, bit3 blue
- color  out  4  one-hot lit button, same bit mapping as btn
- level  out  3  current level; 0 when no game is running
- state  out  2  0 idle, 1 Simon playback, 2 player turn, 3 game over
- win  out  1  high while in WIN
- lose  out  1  high while in LOSE

Behaviour:
- All outputs are registered.
- Reset values: color=0, level=0, state=0, win=0, lose=0. FSM=IDLE, counters=0, sequence RAM cleared, LFSR=8'hA5.
- Colour index to one-hot mapping: 0→4'b0100, 1→4'b0010, 2→4'b0001, 3→4'b1000.
- 8-bit maximal LFSR (taps 8,6,5,4) free-runs every cycle, including in IDLE.
- Sequence storage: MAX_LEVEL entries × 2 bits. On entering round n, entry n-1 ← lfsr[1:0].
- FSM states, listed as FSM → state output:
  - IDLE→0
  - GAP→1, color 0
  - SHOW_ON→1
  - SHOW_OFF→1
  - PLAY→2
  - ECHO→2
  - WIN→3
  - LOSE→3
- IDLE, WIN or LOSE, on start: level←1, append entry 0, idx←0, go to GAP. start is ignored in every other state.
- GAP: wait T_OFF cycles, then SHOW_ON with idx=0.
- SHOW_ON: color=map(seq[idx]) for T_ON cycles, then SHOW_OFF with color 0 for T_OFF cycles.
- After SHOW_OFF: if idx==level-1, go to PLAY with idx←0; else idx++ and return to SHOW_ON.
- PLAY: color=0. btn==0 means hold.
  - btn equal to map(seq[idx]) → ECHO, with color=btn for T_ON cycles.
  - Any other nonzero btn, including multi-hot → LOSE.
- ECHO end:
  - If idx<level-1: idx++, go to PLAY.
  - Else if level==MAX_LEVEL: go to WIN.
  - Else: level++, append new entry, idx←0, go to GAP.
- btn is ignored outside PLAY, including presses during ECHO.
- WIN: color=4'b1111, win=1, level holds.
- LOSE: color=map(seq[idx]) (the expected colour), lose=1, level holds.
- Latency: btn pulse at edge N → color/state change visible after edge N+1.
- Duration counter reloads on every FSM transition. Each timed phase lasts exactly its parameter in cycles.
- start and btn asserted in the same PLAY cycle: start is ignored, btn is processed.
- resetn low at any time immediately forces reset values; the game is abandoned.

Optional Feature:
- Macro: SIMON_TIMEOUT_EN.
- Defined: a TIMEOUT-cycle idle counter runs in PLAY and clears on each accepted press. Expiry → LOSE.
- Undefined: PLAY waits indefinitely; no counter is synthesised.

Decomposition:
- Package simon_pkg holds:
  - FSM state enum.
  - STATE_IDLE/STATE_SHOW/STATE_PLAY/STATE_OVER 2-bit output codes.
  - COLOR_RED/YEL/GRN/BLU one-hot constants.
  - The index-to-one-hot mapping function.
- One sub-module, simon_lfsr: 8-bit free-running LFSR with reset seed, exposing q[7:0].

Test Plan (T_ON=4, T_OFF=2, MAX_LEVEL=2, TIMEOUT=20):
- Reset release → color=0, level=0, state=0, win=lose=0. With no start for 100 cycles, all remain unchanged.
- start pulse → state=1, level=1. After 2 dark cycles, color=map(seq[0]) for exactly 4 cycles, then 2 dark cycles, then state=2.
- In PLAY, press the correct colour → color=btn for 4 cycles. Then state=1, level=2, and two colours play back, seq[0] first.
- Level 2, correct presses for both entries → state=3, win=1, color=4'b1111. A following start → level=1, win=0.
- Level 1, press a wrong colour (then repeat the test with btn=4'b0110) → next cycle state=3, lose=1, color=expected colour.
- SIMON_TIMEOUT_EN defined, no press in PLAY for 20 cycles → lose=1. Undefined, the same stimulus → state stays 2 after 1000 cycles.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_PLAY,
    S_ECHO,
    S_WIN,
    S_LOSE
  } fsm_e;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_SHOW = 2'd1;
  localparam logic [1:0] STATE_PLAY = 2'd2;
  localparam logic [1:0] STATE_OVER = 2'd3;

  localparam logic [3:0] COLOR_RED = 4'b0100;
  localparam logic [3:0] COLOR_YEL = 4'b0010;
  localparam logic [3:0] COLOR_GRN = 4'b0001;
  localparam logic [3:0] COLOR_BLU = 4'b1000;
  localparam logic [3:0] COLOR_ALL = 4'b1111;

  localparam int unsigned LFSR_W    = 8;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  // Two-bit sequence entry to the one-hot button/lamp code.
  function automatic logic [3:0] idx_to_color(input logic [1:0] idx);
    logic [3:0] c;
    unique case (idx)
      2'd0:    c = COLOR_RED;
      2'd1:    c = COLOR_YEL;
      2'd2:    c = COLOR_GRN;
      default: c = COLOR_BLU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4).
module simon_lfsr
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game controller: pattern generation, playback, press checking.
// Define SIMON_TIMEOUT_EN to lose the game after TIMEOUT idle cycles in PLAY.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned T_ON      = 25000000,
  parameter int unsigned T_OFF     = 12500000,
  parameter int unsigned MAX_LEVEL = 5,
  parameter int unsigned TIMEOUT   = 150000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] color,
  output logic [2:0] level,
  output logic [1:0] state,
  output logic       win,
  output logic       lose
);

  localparam int unsigned T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);
  localparam int unsigned IDX_W = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam logic [CNT_W-1:0] LOAD_ON  = CNT_W'(T_ON - 1);
  localparam logic [CNT_W-1:0] LOAD_OFF = CNT_W'(T_OFF - 1);
  localparam logic [2:0]       LVL_MAX  = 3'(MAX_LEVEL);

  fsm_e             fsm_q, fsm_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       idx_q, idx_nxt;
  logic [2:0]       level_nxt;
  logic [1:0]       seq_q [MAX_LEVEL];
  logic             seq_we;
  logic [2:0]       seq_wa;
  logic [LFSR_W-1:0] lfsr_q;
  logic             cnt_done;
  logic [3:0]       cur_color, nxt_color;
  logic [3:0]       color_nxt;
  logic [1:0]       state_nxt;
  logic             win_nxt, lose_nxt;
  logic             unused_lfsr;

`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_q, to_nxt;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  simon_lfsr u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .q      (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[LFSR_W-1:2];
  assign cnt_done    = (cnt_q == '0);
  assign cur_color   = idx_to_color(seq_q[IDX_W'(idx_q)]);
  assign nxt_color   = idx_to_color(seq_q[IDX_W'(idx_nxt)]);

  // Next-state logic and registered-output decode.
  always_comb begin
    fsm_nxt   = fsm_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    level_nxt = level;
    seq_we    = 1'b0;
    seq_wa    = '0;
`ifdef SIMON_TIMEOUT_EN
    to_nxt    = '0;
`endif
    color_nxt = '0;
    state_nxt = STATE_IDLE;
    win_nxt   = 1'b0;
    lose_nxt  = 1'b0;

    unique case (fsm_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          fsm_nxt   = S_GAP;
          level_nxt = 3'd1;
          idx_nxt   = '0;
          seq_we    = 1'b1;
          seq_wa    = '0;
          cnt_nxt   = LOAD_OFF;
        end
      end
      S_GAP: begin
        if (cnt_done) begin
          fsm_nxt = S_SHOW_ON;
          idx_nxt = '0;
          cnt_nxt = LOAD_ON;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      S_SHOW_ON: begin
        if (cnt_done) begin
          fsm_nxt = S_SHOW_OFF;
          cnt_nxt = LOAD_OFF;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      S_SHOW_OFF: begin
        if (!cnt_done) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else if (idx_q == level - 3'd1) begin
          fsm_nxt = S_PLAY;
          idx_nxt = '0;
        end else begin
          fsm_nxt = S_SHOW_ON;
          idx_nxt = idx_q + 3'd1;
          cnt_nxt = LOAD_ON;
        end
      end
      S_PLAY: begin
        if (btn != 4'b0000) begin
          if (btn == cur_color) begin
            fsm_nxt = S_ECHO;
            cnt_nxt = LOAD_ON;
          end else begin
            fsm_nxt = S_LOSE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          fsm_nxt = S_LOSE;
        end else begin
          to_nxt = to_q + TO_W'(1);
        end
`endif
      end
      S_ECHO: begin
        if (!cnt_done) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else if (idx_q < level - 3'd1) begin
          fsm_nxt = S_PLAY;
          idx_nxt = idx_q + 3'd1;
        end else if (level == LVL_MAX) begin
          fsm_nxt = S_WIN;
        end else begin
          fsm_nxt   = S_GAP;
          seq_we    = 1'b1;
          seq_wa    = level;
          level_nxt = level + 3'd1;
          idx_nxt   = '0;
          cnt_nxt   = LOAD_OFF;
        end
      end
      default: fsm_nxt = S_IDLE;
    endcase

    unique case (fsm_nxt)
      S_GAP, S_SHOW_OFF: state_nxt = STATE_SHOW;
      S_SHOW_ON: begin
        state_nxt = STATE_SHOW;
        color_nxt = nxt_color;
      end
      S_PLAY: state_nxt = STATE_PLAY;
      S_ECHO: begin
        state_nxt = STATE_PLAY;
        color_nxt = nxt_color;
      end
      S_WIN: begin
        state_nxt = STATE_OVER;
        color_nxt = COLOR_ALL;
        win_nxt   = 1'b1;
      end
      S_LOSE: begin
        state_nxt = STATE_OVER;
        color_nxt = nxt_color;
        lose_nxt  = 1'b1;
      end
      default: state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      level <= '0;
      color <= '0;
      state <= STATE_IDLE;
      win   <= 1'b0;
      lose  <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      to_q  <= '0;
`endif
    end else begin
      fsm_q <= fsm_nxt;
      cnt_q <= cnt_nxt;
      idx_q <= idx_nxt;
      level <= level_nxt;
      color <= color_nxt;
      state <= state_nxt;
      win   <= win_nxt;
      lose  <= lose_nxt;
`ifdef SIMON_TIMEOUT_EN
      to_q  <= to_nxt;
`endif
    end
  end

  // Sequence RAM: one new entry sampled from the LFSR per round.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < MAX_LEVEL; i++) begin
        seq_q[i] <= 2'b00;
      end
    end else if (seq_we) begin
      seq_q[IDX_W'(seq_wa)] <= lfsr_q[1:0];
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed self-checking bench for simon_sequencer with short timing parameters.
module tb_simon_sequencer;

  localparam int unsigned T_ON      = 4;
  localparam int unsigned T_OFF     = 2;
  localparam int unsigned MAX_LEVEL = 2;
  localparam int unsigned TIMEOUT   = 20;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] btn;
  logic [3:0] color;
  logic [2:0] level;
  logic [1:0] state;
  logic       win;
  logic       lose;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_lfsr;
  logic [1:0] exp_seq [MAX_LEVEL];
  logic [1:0] wrong_idx;

  always #5 clk = ~clk;

  simon_sequencer #(
    .T_ON      (T_ON),
    .T_OFF     (T_OFF),
    .MAX_LEVEL (MAX_LEVEL),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .btn    (btn),
    .color  (color),
    .level  (level),
    .state  (state),
    .win    (win),
    .lose   (lose)
  );

  // Reference LFSR, same seed and taps, tracks the free-running generator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 8'hA5;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] exp_color(input logic [1:0] i);
    logic [3:0] c;
    case (i)
      2'd0:    c = 4'b0100;
      2'd1:    c = 4'b0010;
      2'd2:    c = 4'b0001;
      default: c = 4'b1000;
    endcase
    return c;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check state/colour on n consecutive cycles, advancing one cycle each.
  task automatic expect_cycles(input string tag, input int n, input logic [1:0] st,
                               input logic [3:0] col);
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_state"}, 32'(state), 32'(st));
      check_eq({tag, "_color"}, 32'(color), 32'(col));
      @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_seq[0] = m_lfsr[1:0];
    @(negedge clk);
    start = 1'b0;
    check_eq("start_level", 32'(level), 32'd1);
    check_eq("start_win",   32'(win),   32'd0);
    check_eq("start_lose",  32'(lose),  32'd0);
  endtask

  task automatic run_playback(input int n);
    expect_cycles("gap", T_OFF, 2'd1, 4'b0000);
    for (int i = 0; i < n; i++) begin
      expect_cycles("show", T_ON, 2'd1, exp_color(exp_seq[i]));
      expect_cycles("off", T_OFF, 2'd1, 4'b0000);
    end
    check_eq("play_state", 32'(state), 32'd2);
    check_eq("play_color", 32'(color), 32'd0);
  endtask

  // Correct press of entry i; optional start in the same cycle and a stray press during echo.
  task automatic press_ok(input int i, input int app_idx, input bit with_start, input bit noise);
    logic [3:0] c;
    c = exp_color(exp_seq[i]);
    btn   = c;
    start = with_start;
    @(negedge clk);
    btn   = 4'b0000;
    start = 1'b0;
    if (noise) begin
      btn = 4'b1111;
      expect_cycles("echo", 1, 2'd2, c);
      btn = 4'b0000;
      expect_cycles("echo", T_ON - 2, 2'd2, c);
    end else begin
      expect_cycles("echo", T_ON - 1, 2'd2, c);
    end
    if (app_idx >= 0) exp_seq[app_idx] = m_lfsr[1:0];
    expect_cycles("echo", 1, 2'd2, c);
  endtask

  task automatic check_lose(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd3);
    check_eq({tag, "_lose"},  32'(lose),  32'd1);
    check_eq({tag, "_win"},   32'(win),   32'd0);
    check_eq({tag, "_color"}, 32'(color), 32'(exp_color(exp_seq[0])));
    check_eq({tag, "_level"}, 32'(level), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    btn    = 4'b0000;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    check_eq("rst_color", 32'(color), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_win",   32'(win),   32'd0);
    check_eq("rst_lose",  32'(lose),  32'd0);

    repeat (100) @(negedge clk);
    check_eq("idle_outputs", 32'({color, level, state, win, lose}), 32'd0);

    // Full game to WIN.
    do_start();
    run_playback(1);
    press_ok(0, 1, 1'b0, 1'b0);
    check_eq("lvl2_level", 32'(level), 32'd2);
    run_playback(2);
    check_eq("lvl2_play_level", 32'(level), 32'd2);
    press_ok(0, -1, 1'b1, 1'b0);
    check_eq("lvl2_next_state", 32'(state), 32'd2);
    check_eq("lvl2_next_color", 32'(color), 32'd0);
    press_ok(1, -1, 1'b0, 1'b1);
    check_eq("win_state", 32'(state), 32'd3);
    check_eq("win_win",   32'(win),   32'd1);
    check_eq("win_lose",  32'(lose),  32'd0);
    check_eq("win_color", 32'(color), 32'hF);
    check_eq("win_level", 32'(level), 32'd2);
    @(negedge clk);
    check_eq("win_hold", 32'(win), 32'd1);

    // Restart from WIN, then lose with a wrong single colour.
    do_start();
    run_playback(1);
    wrong_idx = exp_seq[0] + 2'd1;
    btn = exp_color(wrong_idx);
    @(negedge clk);
    btn = 4'b0000;
    check_lose("lose1");

    // Lose with a multi-hot press.
    do_start();
    run_playback(1);
    btn = 4'b0110;
    @(negedge clk);
    btn = 4'b0000;
    check_lose("lose2");

    // Idle in PLAY.
    do_start();
    run_playback(1);
`ifdef SIMON_TIMEOUT_EN
    repeat (TIMEOUT - 1) @(negedge clk);
    check_eq("to_pre_state", 32'(state), 32'd2);
    @(negedge clk);
    check_lose("timeout");
`else
    repeat (1000) @(negedge clk);
    check_eq("no_to_state", 32'(state), 32'd2);
    check_eq("no_to_lose",  32'(lose),  32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
